// File: rtl/framebuf_writer_pkg.sv
// Shared constants and state encoding for the frame-buffer writer.
// The optional FBW_VBLANK_ONLY_EN build uses the window bounds defined here.
package framebuf_writer_pkg;

    localparam int IMG_W_DEF = 240;
    localparam int IMG_H_DEF = 160;
    localparam int ADDR_W    = 16;
    localparam int PIX_W     = 8;
    localparam int VC_W      = 10;

    // Lines 141..299 are the displayed window; writes are held off there.
    localparam logic [VC_W-1:0] WIN_LO = 10'd140;
    localparam logic [VC_W-1:0] WIN_HI = 10'd300;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FILL   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/fb_addr_counter.sv
// Pixel index counter: tracks x/y and the linear address y*IMG_W+x by increment
// only, and flags the final pixel of the frame.
module fb_addr_counter #(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 160,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last;

    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr_i || (inc_i && last)) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = last;

endmodule

// File: rtl/framebuf_writer.sv
// Writes one frame into the frame buffer, either from a pixel stream or as a solid fill.
// Define FBW_VBLANK_ONLY_EN to restrict writes to lines outside the displayed window.
module framebuf_writer
    import framebuf_writer_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              fill_mode,
    input  logic [PIX_W-1:0]  fill_color,
    input  logic              abort,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [VC_W-1:0]   vcount,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [PIX_W-1:0]  dinb,
    output logic              busy,
    output logic              done,
    output state_e            dbg_state_o
);

    // Handshake: a stream pixel is accepted on a rising edge where pix_valid and
    // pix_ready are both high; pix_ready never depends on pix_valid.

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   fill_color_q, fill_color_d;
    logic               web_q;
    logic [ADDR_W-1:0]  addrb_q;
    logic [PIX_W-1:0]   dinb_q;
    logic               allow;
    logic               accept;
    logic               clr;
    logic [PIX_W-1:0]   wdata;
    logic [ADDR_W-1:0]  cnt_addr;
    logic               cnt_last;

`ifdef FBW_VBLANK_ONLY_EN
    assign allow = (vcount <= WIN_LO) || (vcount >= WIN_HI);
`else
    logic unused_vcount;
    assign unused_vcount = ^vcount;
    assign allow = 1'b1;
`endif

    fb_addr_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (clr),
        .inc_i  (accept),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        fill_color_d = fill_color_q;
        clr          = 1'b0;
        accept       = 1'b0;
        pix_ready    = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    clr          = 1'b1;
                    fill_color_d = fill_color;
                    state_d      = fill_mode ? S_FILL : S_STREAM;
                end
            end
            S_STREAM: begin
                pix_ready = allow;
                accept    = pix_valid && allow;
            end
            S_FILL: begin
                accept = allow;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A pixel accepted in the abort cycle is still written; the frame just stops there.
        if (state_q == S_STREAM || state_q == S_FILL) begin
            if (abort) begin
                state_d = S_IDLE;
            end else if (accept && cnt_last) begin
                state_d = S_DONE;
            end
        end
    end

    assign wdata = (state_q == S_FILL) ? fill_color_q : pix_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_color_q <= '0;
            web_q        <= 1'b0;
            addrb_q      <= '0;
            dinb_q       <= '0;
        end else begin
            state_q      <= state_d;
            fill_color_q <= fill_color_d;
            web_q        <= accept;
            if (accept) begin
                addrb_q <= cnt_addr;
                dinb_q  <= wdata;
            end
        end
    end

    assign web         = web_q;
    assign addrb       = addrb_q;
    assign dinb        = dinb_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_framebuf_writer.sv
// Directed bench for framebuf_writer: fill, stream, abort, async reset and vcount sweep,
// with a write scoreboard checked on every web pulse.
module tb_framebuf_writer;
  import framebuf_writer_pkg::*;

  localparam int NPIX = 240 * 160;

  logic        clock;
  logic        reset;
  logic        start;
  logic        fill_mode;
  logic [7:0]  fill_color;
  logic        abort;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  vcount;
  logic        web;
  logic [15:0] addrb;
  logic [7:0]  dinb;
  logic        busy;
  logic        done;
  state_e      dbg_state;

  int total = 0;
  int bad = 0;
  int web_cnt = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [9:0] vc_prev = '0;
  logic sweep_en = 1'b0;
  logic [23:0] exp_q[$];

  framebuf_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .fill_mode   (fill_mode),
    .fill_color  (fill_color),
    .abort       (abort),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .vcount      (vcount),
    .web         (web),
    .addrb       (addrb),
    .dinb        (dinb),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // vcount source: sweeps 0..524 when enabled, else parked on a writable line
  initial begin
    vcount = '0;
    forever begin
      @(posedge clock);
      #1;
      if (sweep_en) vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      else vcount = '0;
    end
  end

  function automatic logic allowed_f(input logic [9:0] vc);
`ifdef FBW_VBLANK_ONLY_EN
    return (vc <= 10'd140) || (vc >= 10'd300);
`else
    return (vc == vc);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard: every web pulse must match the oldest expected {addr,data}
  always @(negedge clock) begin
    if (web) begin
      web_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_web: observed addr %0h data %0h expected no write", addrb, dinb);
      end
      if (exp_q.size() != 0) begin
        logic [23:0] e;
        e = exp_q.pop_front();
        total++;
        assert ({addrb, dinb} === e) else begin
          bad++;
          $error("FAIL write: observed %0h expected %0h", {addrb, dinb}, e);
        end
      end
`ifdef FBW_VBLANK_ONLY_EN
      total++;
      assert (allowed_f(vc_prev)) else begin
        bad++;
        $error("FAIL vblank_write: observed write at vcount %0d expected none in 141..299", vc_prev);
      end
`endif
    end
    if (done) begin
      done_cnt++;
      total++;
      assert (done_prev === 1'b0) else begin
        bad++;
        $error("FAIL done_width: observed %0b expected %0b", done_prev, 1'b0);
      end
    end
    done_prev = done;
    vc_prev = vcount;
  end

  // drivers
  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk(tag, (n < limit), 1);
  endtask

  task automatic run_fill_abort(input logic [7:0] color, input int n);
    for (int i = 0; i <= n; i++) exp_q.push_back({16'(i), color});
    start = 1'b1; fill_mode = 1'b1; fill_color = color;
    @(posedge clock); #1;
    start = 1'b0; fill_color = 8'h00;
    repeat (n) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
  endtask

  initial begin
    int base_web;
    int base_done;
    int n;
    int exp_addr;
    start = 0; fill_mode = 0; fill_color = 0; abort = 0;
    pix_data = 0; pix_valid = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_web", web, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dinb", dinb, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, S_IDLE);
    @(posedge clock); #1 reset = 1'b0;

    // full fill with vcount sweeping
    sweep_en = 1'b1;
    base_web = web_cnt; base_done = done_cnt;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({16'(i), 8'hE3});
    start = 1'b1; fill_mode = 1'b1; fill_color = 8'hE3;
    @(posedge clock); #1;
    start = 1'b0; fill_color = 8'h00;
    @(negedge clock);
    chk("fill_busy", busy, 1);
    chk("fill_pix_ready", pix_ready, 0);
    wait_done("fill_done_timeout", 100000);
    chk("fill_last_addr", addrb, NPIX - 1);
    chk("fill_last_data", dinb, 8'hE3);
    @(negedge clock);
    chk("fill_busy_after", busy, 0);
    chk("fill_done_after", done, 0);
    chk("fill_web_count", web_cnt - base_web, NPIX);
    chk("fill_done_count", done_cnt - base_done, 1);
    chk("fill_queue_empty", exp_q.size(), 0);
    sweep_en = 1'b0;
    @(posedge clock); #1;

    // abort at pixel 1000 of a fill
    base_web = web_cnt; base_done = done_cnt;
    run_fill_abort(8'h3C, 1000);
    repeat (20) @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_web_count", web_cnt - base_web, 1001);
    chk("abort_no_done", done_cnt - base_done, 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    // start and abort together in IDLE
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1; fill_mode = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_state", dbg_state, S_IDLE);

    // restart after abort begins at address 0
    @(posedge clock); #1;
    base_web = web_cnt;
    run_fill_abort(8'h5A, 0);
    repeat (5) @(negedge clock);
    chk("restart_web_count", web_cnt - base_web, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    // async reset at pixel 500
    @(posedge clock); #1;
    base_web = web_cnt;
    for (int i = 0; i <= 500; i++) exp_q.push_back({16'(i), 8'h77});
    start = 1'b1; fill_mode = 1'b1; fill_color = 8'h77;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while ((web_cnt - base_web) < 501 && n < 2000) begin
      @(negedge clock); #1;
      n++;
    end
    chk("reset_reach_500", (n < 2000), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_web", web, 0);
    chk("arst_addrb", addrb, 0);
    chk("arst_dinb", dinb, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_state", dbg_state, S_IDLE);
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("arst_web_count", web_cnt - base_web, 501);
    chk("arst_queue_empty", exp_q.size(), 0);

    // restart after reset: latency and address 0
    @(posedge clock); #1;
    exp_q.push_back({16'd0, 8'h11});
    exp_q.push_back({16'd1, 8'h11});
    start = 1'b1; fill_mode = 1'b1; fill_color = 8'h11;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("lat_web_low", web, 0);
    chk("lat_busy", busy, 1);
    @(posedge clock); #1 abort = 1'b1;
    @(negedge clock);
    chk("lat_web_high", web, 1);
    chk("lat_addr0", addrb, 0);
    chk("lat_data", dinb, 8'h11);
    @(posedge clock); #1 abort = 1'b0;
    repeat (4) @(negedge clock);
    chk("lat_busy_after", busy, 0);
    chk("lat_queue_empty", exp_q.size(), 0);

    // stream with random pix_valid, data = addr[7:0]
    @(posedge clock); #1;
    sweep_en = 1'b1;
    base_web = web_cnt; base_done = done_cnt;
    start = 1'b1; fill_mode = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    exp_addr = 0;
    n = 0;
    while (exp_addr < NPIX && n < 150000) begin
      pix_valid = ($urandom_range(0, 7) != 0);
      pix_data = 8'(exp_addr);
      @(negedge clock);
      chk("stream_pix_ready", pix_ready, allowed_f(vcount));
      if (pix_valid && pix_ready) begin
        exp_q.push_back({16'(exp_addr), 8'(exp_addr)});
        exp_addr++;
      end
      @(posedge clock); #1;
      n++;
    end
    pix_valid = 1'b0;
    chk("stream_budget", (n < 150000), 1);
    @(negedge clock);
    chk("stream_done", done, 1);
    chk("stream_ready_done", pix_ready, 0);
    chk("stream_last_addr", addrb, NPIX - 1);
    repeat (3) @(negedge clock);
    chk("stream_busy_after", busy, 0);
    chk("stream_web_count", web_cnt - base_web, NPIX);
    chk("stream_done_count", done_cnt - base_done, 1);
    chk("stream_queue_empty", exp_q.size(), 0);
    sweep_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
